// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the receive-only I2C slave: widths and one-hot state codes.
package i2c_slave_pkg;

   localparam int STATE_W = 6;
   localparam int COUNT_W = 4;
   localparam int BYTE_W  = 8;

   // Value loaded into the bit counter when the data phase begins.
   localparam logic [COUNT_W-1:0] COUNT_LOAD = COUNT_W'(BYTE_W);

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 6'b000001,
      ST_START = 6'b000010,
      ST_SYNC  = 6'b000100,
      ST_DATA  = 6'b001000,
      ST_ACK   = 6'b010000,
      ST_DONE  = 6'b100000
   } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus history flop for one I2C line.
// Edges are reported between stage 2 and stage 3; all flops reset to 1 (idle bus).
module i2c_sync_edge
(
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   // sync_reg[0] = stage 1, sync_reg[1] = stage 2, sync_reg[2] = history
   logic [2:0] sync_reg;

   // Shift the asynchronous line through the synchronizer chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sync_reg <= 3'b111;
      else
         sync_reg <= {sync_reg[1:0], din};
   end

   assign level = sync_reg[1];
   assign rise  = sync_reg[1] & ~sync_reg[2];
   assign fall  = ~sync_reg[1] & sync_reg[2];

endmodule

// File: rtl/i2c_slave_1.sv
// Receive-only I2C slave: detects START/STOP, skips one setup pulse, shifts in
// one byte MSB first, samples the ACK bit and returns to idle.
// Optional macro I2C_SLAVE_ADDR_FILTER_EN: only store bytes whose [7:5] equals addr.
module i2c_slave_1
   import i2c_slave_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         addr,
   input  logic [BYTE_W-1:0]  data_wr,
   output logic [BYTE_W-1:0]  data_rd,
   input  logic               rw,
   input  logic               scl,
   input  logic               sda,
   output logic               busy,
   output logic [STATE_W-1:0] state,
   output logic [COUNT_W-1:0] count,
   output logic               i2c_clk
);

   logic scl_sync, scl_rise, scl_fall;
   logic sda_sync, sda_rise, sda_fall;
   logic start_det, stop_det;
   logic filter_pass;
   logic unused_inputs;

   state_t              state_reg, state_next;
   logic [BYTE_W-1:0]   shift_reg, shift_next;
   logic [BYTE_W-1:0]   byte_next;
   logic [COUNT_W-1:0]  count_reg, count_next;
   logic [BYTE_W-1:0]   data_rd_reg, data_rd_next;

   i2c_sync_edge u_scl_sync (
      .clk   (clk),
      .reset (reset),
      .din   (scl),
      .level (scl_sync),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_sync_edge u_sda_sync (
      .clk   (clk),
      .reset (reset),
      .din   (sda),
      .level (sda_sync),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   assign start_det = sda_fall & scl_sync;
   assign stop_det  = sda_rise & scl_sync;

   // Shift register contents after the current sampling edge.
   assign byte_next = {shift_reg[BYTE_W-2:0], sda_sync};

`ifdef I2C_SLAVE_ADDR_FILTER_EN
   assign filter_pass   = (byte_next[7:5] == addr);
   assign unused_inputs = ^data_wr;
`else
   assign filter_pass   = 1'b1;
   assign unused_inputs = ^{data_wr, addr};
`endif

   // State, shift register, bit counter and output byte registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         shift_reg   <= '0;
         count_reg   <= '0;
         data_rd_reg <= '0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         count_reg   <= count_next;
         data_rd_reg <= data_rd_next;
      end
   end

   // Next-state logic; STOP aborts and repeated START restarts from any active state.
   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      count_next   = count_reg;
      data_rd_next = data_rd_reg;
      if (state_reg != ST_IDLE && stop_det) begin
         state_next = ST_IDLE;
         count_next = '0;
      end else if (start_det) begin
         state_next = ST_START;
         shift_next = '0;
         count_next = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               state_next = ST_IDLE;
            end
            ST_START: begin
               if (scl_fall)
                  state_next = ST_SYNC;
            end
            ST_SYNC: begin
               // Dummy setup pulse: no data sampled here.
               if (scl_rise) begin
                  state_next = ST_DATA;
                  count_next = COUNT_LOAD;
               end
            end
            ST_DATA: begin
               if (scl_rise) begin
                  shift_next = byte_next;
                  if (count_reg != '0)
                     count_next = count_reg - 1'b1;
                  if (count_reg == COUNT_W'(1)) begin
                     state_next = ST_ACK;
                     if (rw && filter_pass)
                        data_rd_next = byte_next;
                  end
               end
            end
            ST_ACK: begin
               // ACK or NACK both proceed; the bit value is not acted on.
               if (scl_rise)
                  state_next = ST_DONE;
            end
            ST_DONE: begin
               if (scl_rise && sda_sync)
                  state_next = ST_IDLE;
            end
            default: begin
               state_next = ST_IDLE;
               count_next = '0;
            end
         endcase
      end
   end

   assign busy    = (state_reg != ST_IDLE);
   assign state   = state_reg;
   assign count   = count_reg;
   assign data_rd = data_rd_reg;
   assign i2c_clk = scl_sync;

endmodule

// File: tb/tb_i2c_slave_1.sv
// Directed, table-driven bench for i2c_slave_1 (100 ns clk, bus driven on clk falling edges).
module tb_i2c_slave_1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] addr = 3'b000;
   logic [7:0] data_wr = 8'h00;
   logic [7:0] data_rd;
   logic       rw = 1'b1;
   logic       scl = 1'b1;
   logic       sda = 1'b1;
   logic       busy;
   logic [5:0] state;
   logic [3:0] count;
   logic       i2c_clk;

   int checks = 0;
   int failures = 0;

   localparam logic [5:0] S_IDLE  = 6'b000001;
   localparam logic [5:0] S_START = 6'b000010;
   localparam logic [5:0] S_SYNC  = 6'b000100;
   localparam logic [5:0] S_DATA  = 6'b001000;
   localparam logic [5:0] S_ACK   = 6'b010000;
   localparam logic [5:0] S_DONE  = 6'b100000;

   typedef struct {
      logic       do_reset;
      logic       rw;
      logic [2:0] addr;
      logic [7:0] data;
      logic       ack;
      logic [7:0] exp_rd;
      logic [7:0] exp_rd_filt;
   } vec_t;

   vec_t vecs[9];

   i2c_slave_1 dut (
      .clk     (clk),
      .reset   (reset),
      .addr    (addr),
      .data_wr (data_wr),
      .data_rd (data_rd),
      .rw      (rw),
      .scl     (scl),
      .sda     (sda),
      .busy    (busy),
      .state   (state),
      .count   (count),
      .i2c_clk (i2c_clk)
   );

   always #50 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reset with the bus idle and confirm reset values.
   task automatic do_reset();
      reset = 1'b1;
      scl = 1'b1;
      sda = 1'b1;
      #200;
      check("rst_state", {2'b00, state}, {2'b00, S_IDLE});
      check("rst_busy", {7'b0, busy}, 8'h00);
      check("rst_count", {4'b0, count}, 8'h00);
      check("rst_data_rd", data_rd, 8'h00);
      check("rst_i2c_clk", {7'b0, i2c_clk}, 8'h01);
      reset = 1'b0;
      #300;
   endtask

   // One scl pulse carrying bit b; sda changes well inside the low phase.
   task automatic pulse(input logic b);
      #100 sda = b;
      #200 scl = 1'b1;
      #200 scl = 1'b0;
      #100;
   endtask

   // START condition then scl falling edge into SYNC.
   task automatic start_cond();
      check("idle_i2c_clk", {7'b0, i2c_clk}, 8'h01);
      sda = 1'b0;
      #300;
      check("start_state", {2'b00, state}, {2'b00, S_START});
      check("start_busy", {7'b0, busy}, 8'h01);
      check("start_count", {4'b0, count}, 8'h00);
      scl = 1'b0;
      #300;
      check("sync_state", {2'b00, state}, {2'b00, S_SYNC});
      check("low_i2c_clk", {7'b0, i2c_clk}, 8'h00);
   endtask

   // Dummy pulse, 8 data bits, ACK bit, final pulse with sda=1; bus left idle.
   task automatic send_byte(input logic [7:0] b, input logic ack_bit, input logic [7:0] exp_rd);
      pulse(1'b0);
      check("data_state", {2'b00, state}, {2'b00, S_DATA});
      check("data_count", {4'b0, count}, 8'h08);
      for (int i = 7; i >= 0; i--)
         pulse(b[i]);
      check("ack_state", {2'b00, state}, {2'b00, S_ACK});
      check("ack_count", {4'b0, count}, 8'h00);
      check("byte_data_rd", data_rd, exp_rd);
      pulse(ack_bit);
      check("done_state", {2'b00, state}, {2'b00, S_DONE});
      check("done_busy", {7'b0, busy}, 8'h01);
      pulse(1'b1);
      check("end_state", {2'b00, state}, {2'b00, S_IDLE});
      check("end_busy", {7'b0, busy}, 8'h00);
      scl = 1'b1;
      #300;
   endtask

   initial begin
      logic [7:0] exp;

      vecs[0] = '{1'b1, 1'b1, 3'b101, 8'hAA, 1'b0, 8'hAA, 8'hAA};
      vecs[1] = '{1'b1, 1'b0, 3'b101, 8'hAA, 1'b0, 8'h00, 8'h00};
      vecs[2] = '{1'b1, 1'b1, 3'b000, 8'hAA, 1'b0, 8'hAA, 8'h00};
      vecs[3] = '{1'b0, 1'b1, 3'b101, 8'hAA, 1'b1, 8'hAA, 8'hAA};
      vecs[4] = '{1'b0, 1'b1, 3'b010, 8'h55, 1'b0, 8'h55, 8'h55};
      vecs[5] = '{1'b0, 1'b0, 3'b001, 8'h3C, 1'b0, 8'h55, 8'h55};
      vecs[6] = '{1'b0, 1'b1, 3'b001, 8'h3C, 1'b0, 8'h3C, 8'h3C};
      vecs[7] = '{1'b0, 1'b1, 3'b111, 8'hFF, 1'b0, 8'hFF, 8'hFF};
      vecs[8] = '{1'b0, 1'b1, 3'b000, 8'h01, 1'b1, 8'h01, 8'h01};

      #100;
      do_reset();

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].do_reset)
            do_reset();
         rw = vecs[i].rw;
         addr = vecs[i].addr;
`ifdef I2C_SLAVE_ADDR_FILTER_EN
         exp = vecs[i].exp_rd_filt;
`else
         exp = vecs[i].exp_rd;
`endif
         start_cond();
         send_byte(vecs[i].data, vecs[i].ack, exp);
         $display("vec %0d byte=%h rw=%b addr=%b ack=%b data_rd=%h", i,
                  vecs[i].data, vecs[i].rw, vecs[i].addr, vecs[i].ack, data_rd);
      end

      // STOP after 4 data bits aborts without touching data_rd.
      rw = 1'b1;
      addr = 3'b000;
      start_cond();
      pulse(1'b0);
      pulse(1'b1); pulse(1'b0); pulse(1'b1); pulse(1'b0);
      check("stop_count4", {4'b0, count}, 8'h04);
      #100 sda = 1'b0;
      #200 scl = 1'b1;
      #300;
      check("stop_count3", {4'b0, count}, 8'h03);
      sda = 1'b1;
      #300;
      check("stop_state", {2'b00, state}, {2'b00, S_IDLE});
      check("stop_busy", {7'b0, busy}, 8'h00);
      check("stop_count", {4'b0, count}, 8'h00);
      check("stop_data_rd", data_rd, 8'h01);
      $display("stop after 4 bits state=%b busy=%b data_rd=%h", state, busy, data_rd);

      // Repeated START mid-byte clears count, then a full byte is received.
      addr = 3'b110;
      start_cond();
      pulse(1'b0);
      pulse(1'b0); pulse(1'b1); pulse(1'b1);
      #100 sda = 1'b1;
      #200 scl = 1'b1;
      #300;
      check("rs_count4", {4'b0, count}, 8'h04);
      sda = 1'b0;
      #300;
      check("rs_state", {2'b00, state}, {2'b00, S_START});
      check("rs_count", {4'b0, count}, 8'h00);
      check("rs_busy", {7'b0, busy}, 8'h01);
      scl = 1'b0;
      #300;
      check("rs_sync_state", {2'b00, state}, {2'b00, S_SYNC});
      send_byte(8'hC3, 1'b0, 8'hC3);
      $display("repeated start byte=c3 data_rd=%h", data_rd);

      // Reset asserted during bit 5 discards the byte at once.
      addr = 3'b010;
      start_cond();
      pulse(1'b0);
      pulse(1'b0); pulse(1'b1); pulse(1'b0); pulse(1'b1);
      #100 sda = 1'b1;
      #200 scl = 1'b1;
      #100 reset = 1'b1;
      #1;
      check("mid_rst_state", {2'b00, state}, {2'b00, S_IDLE});
      check("mid_rst_busy", {7'b0, busy}, 8'h00);
      check("mid_rst_count", {4'b0, count}, 8'h00);
      check("mid_rst_data_rd", data_rd, 8'h00);
      check("mid_rst_i2c_clk", {7'b0, i2c_clk}, 8'h01);
      #99;
      #200 reset = 1'b0;
      #300;
      start_cond();
      send_byte(8'h5A, 1'b0, 8'h5A);
      $display("reset mid-byte then byte=5a data_rd=%h", data_rd);

      // Reset released with sda already low and scl high gives START within 3 clk.
      reset = 1'b1;
      scl = 1'b1;
      sda = 1'b0;
      #200 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rel_start_state", {2'b00, state}, {2'b00, S_START});
      check("rel_start_busy", {7'b0, busy}, 8'h01);
      $display("reset release with sda low state=%b busy=%b", state, busy);
      #49;
      reset = 1'b1;
      sda = 1'b1;
      #200;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
